// File: rtl/datav_pkg.sv
// Shared widths, control encodings and small helpers for the datav multicycle datapath.
package datav_pkg;

    localparam int WIDTH   = 8;
    localparam int REGBITS = 3;
    localparam int NREGS   = 1 << REGBITS;
    localparam int INSTR_W = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_ONE  = 2'b01,
        SRCB_IMM  = 2'b10,
        SRCB_IMM4 = 2'b11
    } srcb_sel_e;

    typedef enum logic [1:0] {
        PC_ALU     = 2'b00,
        PC_ALUOUT  = 2'b01,
        PC_JUMP    = 2'b10,
        PC_ALU_ALT = 2'b11
    } pcsrc_sel_e;

    // Word-aligned byte offset taken from the low six instruction bits.
    function automatic logic [WIDTH-1:0] imm_x4(input logic [5:0] field);
        return {field, 2'b00};
    endfunction

endpackage

// File: rtl/datav_if.sv
// Controller/memory bus of the datav datapath: control strobes, memory byte bus and status.
interface datav_if;
    import datav_pkg::*;

    logic [WIDTH-1:0]   memdata;
    logic               alusrca;
    logic               memtoreg;
    logic               regdst;
    logic               iord;
    logic               pcen;
    logic               regwrite;
    logic [1:0]         pcsrc;
    logic [1:0]         alusrcb;
    logic [3:0]         irwrite;
    logic [2:0]         alucontrol;
    logic               zero;
    logic [INSTR_W-1:0] instr;
    logic [WIDTH-1:0]   adr;
    logic [WIDTH-1:0]   writedata;

    modport master (
        output memdata, alusrca, memtoreg, regdst, iord, pcen, regwrite,
               pcsrc, alusrcb, irwrite, alucontrol,
        input  zero, instr, adr, writedata
    );

    modport slave (
        input  memdata, alusrca, memtoreg, regdst, iord, pcen, regwrite,
               pcsrc, alusrcb, irwrite, alucontrol,
        output zero, instr, adr, writedata
    );

endinterface

// File: rtl/datav_regfile.sv
// 8x8 register file: two combinational read ports, one clocked write port, register 0 hardwired to zero.
module datav_regfile
    import datav_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Next register contents: only a non-zero write address is honoured.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != {REGBITS{1'b0}})) begin
            regs_d[wa] = wd;
        end else begin
            regs_d[wa] = regs_q[wa];
        end
    end

    // Storage; no write bypass, so a same-cycle read still returns the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with register 0 forced to zero.
    always_comb begin
        if (ra1 == {REGBITS{1'b0}}) begin
            rd1 = {WIDTH{1'b0}};
        end else begin
            rd1 = regs_q[ra1];
        end
        if (ra2 == {REGBITS{1'b0}}) begin
            rd2 = {WIDTH{1'b0}};
        end else begin
            rd2 = regs_q[ra2];
        end
    end

endmodule

// File: rtl/datav.sv
// datav: 8-bit multicycle MIPS-subset datapath (PC, IR, MDR, A, B, ALUOut, register file, ALU).
// Build option: define DATAV_SLT_EN to enable the unsigned set-less-than ALU operation.
module datav
    import datav_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    datav_if.slave bus
);

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   aluout_q, aluout_d;

    logic [WIDTH-1:0]   rd1_s, rd2_s;
    logic [WIDTH-1:0]   src_a_s, src_b_s, alu_res_s, wdata_s;
    logic [REGBITS-1:0] waddr_s;

    // Register write path: rd or rt field, ALUOut or MDR.
    always_comb begin
        if (bus.regdst) begin
            waddr_s = instr_q[11 +: REGBITS];
        end else begin
            waddr_s = instr_q[16 +: REGBITS];
        end
        if (bus.memtoreg) begin
            wdata_s = mdr_q;
        end else begin
            wdata_s = aluout_q;
        end
    end

    datav_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (bus.regwrite),
        .ra1   (instr_q[21 +: REGBITS]),
        .ra2   (instr_q[16 +: REGBITS]),
        .wa    (waddr_s),
        .wd    (wdata_s),
        .rd1   (rd1_s),
        .rd2   (rd2_s)
    );

    // ALU operand selection.
    always_comb begin
        if (bus.alusrca) begin
            src_a_s = a_q;
        end else begin
            src_a_s = pc_q;
        end
        case (bus.alusrcb)
            SRCB_B:    src_b_s = b_q;
            SRCB_ONE:  src_b_s = {{(WIDTH-1){1'b0}}, 1'b1};
            SRCB_IMM:  src_b_s = instr_q[WIDTH-1:0];
            SRCB_IMM4: src_b_s = imm_x4(instr_q[5:0]);
            default:   src_b_s = b_q;
        endcase
    end

    // ALU; unlisted codes (and SLT when the comparator is not built) yield zero.
    always_comb begin
        case (bus.alucontrol)
            ALU_AND: alu_res_s = src_a_s & src_b_s;
            ALU_OR:  alu_res_s = src_a_s | src_b_s;
            ALU_ADD: alu_res_s = src_a_s + src_b_s;
            ALU_SUB: alu_res_s = src_a_s - src_b_s;
`ifdef DATAV_SLT_EN
            ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, (src_a_s < src_b_s)};
`else
            ALU_SLT: alu_res_s = {WIDTH{1'b0}};
`endif
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state for PC, IR bytes and the per-cycle pipeline latches.
    always_comb begin
        pc_d = pc_q;
        if (bus.pcen) begin
            case (bus.pcsrc)
                PC_ALU:     pc_d = alu_res_s;
                PC_ALUOUT:  pc_d = aluout_q;
                PC_JUMP:    pc_d = imm_x4(instr_q[5:0]);
                PC_ALU_ALT: pc_d = alu_res_s;
                default:    pc_d = alu_res_s;
            endcase
        end else begin
            pc_d = pc_q;
        end
        instr_d = instr_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.irwrite[i]) begin
                instr_d[8*i +: 8] = bus.memdata;
            end else begin
                instr_d[8*i +: 8] = instr_q[8*i +: 8];
            end
        end
        mdr_d    = bus.memdata;
        a_d      = rd1_s;
        b_d      = rd2_s;
        aluout_d = alu_res_s;
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= {WIDTH{1'b0}};
            instr_q  <= {INSTR_W{1'b0}};
            mdr_q    <= {WIDTH{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            aluout_q <= {WIDTH{1'b0}};
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    assign bus.zero      = (alu_res_s == {WIDTH{1'b0}});
    assign bus.instr     = instr_q;
    assign bus.writedata = b_q;
    assign bus.adr       = bus.iord ? aluout_q : pc_q;

endmodule

// File: tb/tb_datav.sv
// Testbench for datav: directed test-plan steps plus random control sequences against a reference model.
module tb_datav;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    datav_if bus ();

    datav u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference machine state
    logic [7:0]  m_regs [8];
    logic [7:0]  m_pc, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_ir;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return 8'((int'(x) + int'(y)) % 256);
            3'd6: return 8'((int'(x) - int'(y) + 256) % 256);
`ifdef DATAV_SLT_EN
            3'd7: return (int'(x) < int'(y)) ? 8'h01 : 8'h00;
`endif
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ref_result();
        logic [7:0] sa, sb;
        sa = bus.alusrca ? m_a : m_pc;
        case (bus.alusrcb)
            2'd0:    sb = m_b;
            2'd1:    sb = 8'h01;
            2'd2:    sb = m_ir[7:0];
            default: sb = 8'(int'(m_ir[5:0]) * 4);
        endcase
        return alu_ref(bus.alucontrol, sa, sb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_pc = 8'h00; m_mdr = 8'h00; m_a = 8'h00; m_b = 8'h00; m_aluout = 8'h00;
        m_ir = 32'h0;
    endtask

    task automatic model_edge();
        logic [7:0] res, na, nb;
        logic [2:0] wa;
        res = ref_result();
        na  = m_regs[m_ir[23:21]];
        nb  = m_regs[m_ir[18:16]];
        wa  = bus.regdst ? m_ir[13:11] : m_ir[18:16];
        if (bus.regwrite && wa != 3'd0) m_regs[wa] = bus.memtoreg ? m_mdr : m_aluout;
        if (bus.pcen) begin
            case (bus.pcsrc)
                2'd1:    m_pc = m_aluout;
                2'd2:    m_pc = 8'(int'(m_ir[5:0]) * 4);
                default: m_pc = res;
            endcase
        end
        for (int i = 0; i < 4; i++) if (bus.irwrite[i]) m_ir[8*i +: 8] = bus.memdata;
        m_mdr = bus.memdata;
        m_a = na;
        m_b = nb;
        m_aluout = res;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] res;
        res = ref_result();
        chk({tag, ".adr"},   {24'h0, bus.adr},       {24'h0, bus.iord ? m_aluout : m_pc});
        chk({tag, ".zero"},  {31'h0, bus.zero},      {31'h0, res == 8'h00});
        chk({tag, ".instr"}, bus.instr,              m_ir);
        chk({tag, ".wd"},    {24'h0, bus.writedata}, {24'h0, m_b});
    endtask

    // Settle, compare against the model, then clock both DUT and model once.
    task automatic step(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.memdata = 8'h00; bus.alusrca = 1'b0; bus.memtoreg = 1'b0; bus.regdst = 1'b0;
        bus.iord = 1'b0; bus.pcen = 1'b0; bus.regwrite = 1'b0; bus.pcsrc = 2'd0;
        bus.alusrcb = 2'd0; bus.irwrite = 4'd0; bus.alucontrol = 3'd0;
    endtask

    task automatic randomize_inputs();
        bus.memdata = 8'($urandom); bus.alusrca = 1'($urandom); bus.memtoreg = 1'($urandom);
        bus.regdst = 1'($urandom); bus.iord = 1'($urandom); bus.pcen = 1'($urandom);
        bus.regwrite = 1'($urandom); bus.pcsrc = 2'($urandom); bus.alusrcb = 2'($urandom);
        bus.irwrite = 4'($urandom); bus.alucontrol = 3'($urandom);
    endtask

    task automatic load_ir(input logic [3:0] lanes, input logic [7:0] value);
        idle();
        bus.irwrite = lanes;
        bus.memdata = value;
        step("load_ir");
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        #12;
        chk("rst0_instr", bus.instr, 32'h0);
        chk("rst0_adr",   {24'h0, bus.adr}, 32'h0);
        chk("rst0_wd",    {24'h0, bus.writedata}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // IR assembly, one byte per cycle
        load_ir(4'b0001, 8'h20);
        load_ir(4'b0010, 8'h20);
        load_ir(4'b0100, 8'h85);
        load_ir(4'b1000, 8'h00);
        chk("ir_assembled", bus.instr, 32'h00852020);
        for (int i = 0; i < 3; i++) begin
            bus.memdata = 8'($urandom);
            step("ir_hold");
        end
        chk("ir_held", bus.instr, 32'h00852020);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            step("pre_rst");
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_instr", bus.instr, 32'h0);
        bus.iord = 1'b1;
        #1;
        chk("rst_adr", {24'h0, bus.adr}, 32'h0);
        chk("rst_wd",  {24'h0, bus.writedata}, 32'h0);
        idle();
        @(negedge clk);
        reset = 1'b1;

        // PC increment from reset
        bus.alusrcb = 2'd1; bus.alucontrol = 3'd2; bus.pcen = 1'b1;
        step("pc_inc1"); chk("pc_adr1", {24'h0, bus.adr}, 32'h01);
        step("pc_inc2"); chk("pc_adr2", {24'h0, bus.adr}, 32'h02);
        step("pc_inc3"); chk("pc_adr3", {24'h0, bus.adr}, 32'h03);
        bus.pcen = 1'b0;
        step("pc_hold"); chk("pc_held", {24'h0, bus.adr}, 32'h03);

        // Load 3 into r4 and 4 into r5 through MDR
        load_ir(4'b0100, 8'h04);
        bus.memdata = 8'h03; step("mdr3");
        idle(); bus.memtoreg = 1'b1; bus.regwrite = 1'b1; step("wr_r4");
        load_ir(4'b0100, 8'h05);
        bus.memdata = 8'h04; step("mdr4");
        idle(); bus.memtoreg = 1'b1; bus.regwrite = 1'b1; step("wr_r5");

        // add r4, r4, r5
        load_ir(4'b0001, 8'h20);
        load_ir(4'b0010, 8'h20);
        load_ir(4'b0100, 8'h85);
        load_ir(4'b1000, 8'h00);
        step("latch_ab");
        chk("wd_r5", {24'h0, bus.writedata}, 32'h04);
        bus.alusrca = 1'b1; bus.alucontrol = 3'd2;
        step("add_exec");
        idle(); bus.regdst = 1'b1; bus.regwrite = 1'b1;
        step("add_wb");
        idle();
        step("reread");
        bus.alusrca = 1'b1; bus.alusrcb = 2'd1; bus.alucontrol = 3'd1;
        step("r4_or1");
        idle(); bus.iord = 1'b1;
        #1; chk("r4_sum", {24'h0, bus.adr}, 32'h07);

        // SUB equal operands -> zero
        load_ir(4'b0100, 8'hA5);
        step("latch_r5r5");
        bus.alusrca = 1'b1; bus.alucontrol = 3'd6;
        #1; chk("sub_zero", {31'h0, bus.zero}, 32'h1);
        step("sub_exec");

        // SLT 3 < 4
        load_ir(4'b0100, 8'h03);
        bus.memdata = 8'h03; step("mdr3b");
        idle(); bus.memtoreg = 1'b1; bus.regwrite = 1'b1; step("wr_r3");
        load_ir(4'b0100, 8'h65);
        step("latch_r3r5");
        bus.alusrca = 1'b1; bus.alucontrol = 3'd7;
`ifdef DATAV_SLT_EN
        #1; chk("slt_zero", {31'h0, bus.zero}, 32'h0);
        step("slt_exec");
        idle(); bus.iord = 1'b1;
        #1; chk("slt_result", {24'h0, bus.adr}, 32'h01);
`else
        #1; chk("slt_zero", {31'h0, bus.zero}, 32'h1);
        step("slt_exec");
        idle(); bus.iord = 1'b1;
        #1; chk("slt_result", {24'h0, bus.adr}, 32'h00);
`endif

        // Jump target and ALUOut addressing
        load_ir(4'b0001, 8'h05);
        bus.pcsrc = 2'd2; bus.pcen = 1'b1;
        step("jump");
        idle();
        #1; chk("jump_adr", {24'h0, bus.adr}, 32'h14);
        load_ir(4'b0001, 8'h28);
        bus.alusrcb = 2'd2; bus.alucontrol = 3'd2;
        step("calc_3c");
        idle(); bus.iord = 1'b1;
        #1; chk("iord_adr", {24'h0, bus.adr}, 32'h3C);

        // Write aimed at r0 is dropped
        load_ir(4'b0100, 8'h00);
        bus.regwrite = 1'b1; bus.memdata = 8'hAA; step("mdr_aa");
        bus.memtoreg = 1'b1; step("wr_r0");
        idle(); step("latch_r0");
        chk("r0_zero", {24'h0, bus.writedata}, 32'h00);

        // Random control sequences against the model
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
